// File: rtl/rbus_pkg.sv
// Shared sizing helpers and column arithmetic for the reconfigurable-bus
// counter/lane-map datapath.
package rbus_pkg;

  localparam int RBUS_MAX_W = 16;

  typedef logic [RBUS_MAX_W-1:0] rbus_word_t;

  // Counter width for a given modulus; a modulus of 1 or 2 still needs one bit.
  function automatic int rbus_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One lane-map entry is {valid, column}.
  function automatic int rbus_entry_width(input int col_max);
    return rbus_width(col_max) + 1;
  endfunction

  // (a + b) mod m for a, b < m: widen by one bit, then conditionally subtract.
  function automatic rbus_word_t rbus_mod_add(input rbus_word_t a,
                                              input rbus_word_t b,
                                              input rbus_word_t m);
    logic [RBUS_MAX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      sum = sum - {1'b0, m};
    end
    return sum[RBUS_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rbus_mod_counter.sv
// Modulo-N counter with active-low synchronous clear, load and enable
// (priority clear > load > enable), plus a terminal-count flag.
module rbus_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             RBUS_MOD_COUNTER_Clk,
  input  logic             RBUS_MOD_COUNTER_Reset,
  input  logic             RBUS_MOD_COUNTER_Clr,
  input  logic             RBUS_MOD_COUNTER_Load,
  input  logic             RBUS_MOD_COUNTER_En,
  input  logic [WIDTH-1:0] RBUS_MOD_COUNTER_Load_Val,
  output logic [WIDTH-1:0] RBUS_MOD_COUNTER_Count,
  output logic             RBUS_MOD_COUNTER_Last
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);

  always_ff @(posedge RBUS_MOD_COUNTER_Clk or negedge RBUS_MOD_COUNTER_Reset) begin
    if (!RBUS_MOD_COUNTER_Reset) begin
      RBUS_MOD_COUNTER_Count <= '0;
    end else if (!RBUS_MOD_COUNTER_Clr) begin
      RBUS_MOD_COUNTER_Count <= '0;
    end else if (RBUS_MOD_COUNTER_Load) begin
      RBUS_MOD_COUNTER_Count <= RBUS_MOD_COUNTER_Load_Val;
    end else if (RBUS_MOD_COUNTER_En) begin
      RBUS_MOD_COUNTER_Count <= RBUS_MOD_COUNTER_Last ? '0 : RBUS_MOD_COUNTER_Count + 1'b1;
    end
  end

  assign RBUS_MOD_COUNTER_Last = (RBUS_MOD_COUNTER_Count == LAST_VAL);

endmodule

// File: rtl/rbus_conf_counters.sv
// Counter/lane-map datapath for the reconfigurable bus: counts kernel width,
// columns and lanes for the control FSM and builds the lane -> column map.
module rbus_conf_counters import rbus_pkg::*; #(
  parameter int   BUS_LANES = 16,
  parameter int   W_SIZE    = 3,
  parameter int   COL_MAX   = 32,
  localparam int  LANE_W    = rbus_width(BUS_LANES),
  localparam int  COL_W     = rbus_width(COL_MAX),
  localparam int  ENTRY_W   = rbus_entry_width(COL_MAX)
) (
  input  logic                         RBUS_CONF_COUNTERS_Clk,
  input  logic                         RBUS_CONF_COUNTERS_Reset,
  input  logic                         RBUS_CONF_COUNTERS_Counter_W_Size_En,
  input  logic                         RBUS_CONF_COUNTERS_Counter_W_Size_Clr,
  input  logic                         RBUS_CONF_COUNTERS_Counter_W_Col_En,
  input  logic                         RBUS_CONF_COUNTERS_Counter_W_Col_Load,
  input  logic                         RBUS_CONF_COUNTERS_Counter_W_Col_Clr,
  input  logic                         RBUS_CONF_COUNTERS_Counter_Input_Clr,
  input  logic                         RBUS_CONF_COUNTERS_Counter_Input_Load,
  input  logic                         RBUS_CONF_COUNTERS_Counter_Bus_En,
  input  logic                         RBUS_CONF_COUNTERS_Counter_Bus_Clr,
  input  logic                         RBUS_CONF_COUNTERS_Conf_Rutine,
  input  logic                         RBUS_CONF_COUNTERS_Set_Conf_Already,
  input  logic [COL_W-1:0]             RBUS_CONF_COUNTERS_Start_Col,
  input  logic [COL_W-1:0]             RBUS_CONF_COUNTERS_Input_Base,
  output logic                         RBUS_CONF_COUNTERS_Counter_W_Size_Flag,
  output logic                         RBUS_CONF_COUNTERS_Counter_Bus_Flag,
  output logic                         RBUS_CONF_COUNTERS_Conf_Already_Ok,
  output logic [BUS_LANES*ENTRY_W-1:0] RBUS_CONF_COUNTERS_Lane_Map,
  output logic                         RBUS_CONF_COUNTERS_Map_Valid
);

  localparam int WSZ_W = rbus_width(W_SIZE);

  logic [WSZ_W-1:0]  wsz;
  logic [COL_W-1:0]  wcol;
  logic [COL_W-1:0]  inoff;
  logic [LANE_W-1:0] lane;
  logic              wsz_last;
  logic              wcol_last;
  logic              inoff_last;
  logic              lane_last;
  logic              unused_last;
  logic [COL_W-1:0]  start_col_mod;
  logic [COL_W-1:0]  src;
  logic              conf_ok;
  logic              map_write;
  logic [ENTRY_W-1:0] lane_map [BUS_LANES];

  // A Start_Col at or beyond COL_MAX folds back into range before loading.
  assign start_col_mod = COL_W'(rbus_mod_add(rbus_word_t'(RBUS_CONF_COUNTERS_Start_Col),
                                             rbus_word_t'(0),
                                             rbus_word_t'(COL_MAX)));
  assign src           = COL_W'(rbus_mod_add(rbus_word_t'(wcol),
                                             rbus_word_t'(inoff),
                                             rbus_word_t'(COL_MAX)));

  rbus_mod_counter #(.WIDTH(WSZ_W), .MODULUS(W_SIZE)) u_wsz (
    .RBUS_MOD_COUNTER_Clk      (RBUS_CONF_COUNTERS_Clk),
    .RBUS_MOD_COUNTER_Reset    (RBUS_CONF_COUNTERS_Reset),
    .RBUS_MOD_COUNTER_Clr      (RBUS_CONF_COUNTERS_Counter_W_Size_Clr),
    .RBUS_MOD_COUNTER_Load     (1'b0),
    .RBUS_MOD_COUNTER_En       (RBUS_CONF_COUNTERS_Counter_W_Size_En),
    .RBUS_MOD_COUNTER_Load_Val ({WSZ_W{1'b0}}),
    .RBUS_MOD_COUNTER_Count    (wsz),
    .RBUS_MOD_COUNTER_Last     (wsz_last)
  );

  rbus_mod_counter #(.WIDTH(COL_W), .MODULUS(COL_MAX)) u_wcol (
    .RBUS_MOD_COUNTER_Clk      (RBUS_CONF_COUNTERS_Clk),
    .RBUS_MOD_COUNTER_Reset    (RBUS_CONF_COUNTERS_Reset),
    .RBUS_MOD_COUNTER_Clr      (RBUS_CONF_COUNTERS_Counter_W_Col_Clr),
    .RBUS_MOD_COUNTER_Load     (RBUS_CONF_COUNTERS_Counter_W_Col_Load),
    .RBUS_MOD_COUNTER_En       (RBUS_CONF_COUNTERS_Counter_W_Col_En),
    .RBUS_MOD_COUNTER_Load_Val (start_col_mod),
    .RBUS_MOD_COUNTER_Count    (wcol),
    .RBUS_MOD_COUNTER_Last     (wcol_last)
  );

  rbus_mod_counter #(.WIDTH(COL_W), .MODULUS(COL_MAX)) u_inoff (
    .RBUS_MOD_COUNTER_Clk      (RBUS_CONF_COUNTERS_Clk),
    .RBUS_MOD_COUNTER_Reset    (RBUS_CONF_COUNTERS_Reset),
    .RBUS_MOD_COUNTER_Clr      (RBUS_CONF_COUNTERS_Counter_Input_Clr),
    .RBUS_MOD_COUNTER_Load     (RBUS_CONF_COUNTERS_Counter_Input_Load),
    .RBUS_MOD_COUNTER_En       (1'b0),
    .RBUS_MOD_COUNTER_Load_Val (RBUS_CONF_COUNTERS_Input_Base),
    .RBUS_MOD_COUNTER_Count    (inoff),
    .RBUS_MOD_COUNTER_Last     (inoff_last)
  );

  rbus_mod_counter #(.WIDTH(LANE_W), .MODULUS(BUS_LANES)) u_lane (
    .RBUS_MOD_COUNTER_Clk      (RBUS_CONF_COUNTERS_Clk),
    .RBUS_MOD_COUNTER_Reset    (RBUS_CONF_COUNTERS_Reset),
    .RBUS_MOD_COUNTER_Clr      (RBUS_CONF_COUNTERS_Counter_Bus_Clr),
    .RBUS_MOD_COUNTER_Load     (1'b0),
    .RBUS_MOD_COUNTER_En       (RBUS_CONF_COUNTERS_Counter_Bus_En),
    .RBUS_MOD_COUNTER_Load_Val ({LANE_W{1'b0}}),
    .RBUS_MOD_COUNTER_Count    (lane),
    .RBUS_MOD_COUNTER_Last     (lane_last)
  );

  assign unused_last = &{1'b0, wcol_last, inoff_last};

  assign RBUS_CONF_COUNTERS_Counter_W_Size_Flag = RBUS_CONF_COUNTERS_Counter_W_Size_En & wsz_last;
  assign RBUS_CONF_COUNTERS_Counter_Bus_Flag    = RBUS_CONF_COUNTERS_Counter_Bus_En & lane_last;

  assign map_write = RBUS_CONF_COUNTERS_Counter_Bus_En & RBUS_CONF_COUNTERS_Conf_Rutine;

  // Starting a configuration invalidates every lane; the column fields are
  // left as-is since nothing reads them while valid is low.
  always_ff @(posedge RBUS_CONF_COUNTERS_Clk or negedge RBUS_CONF_COUNTERS_Reset) begin
    if (!RBUS_CONF_COUNTERS_Reset) begin
      for (int i = 0; i < BUS_LANES; i++) begin
        lane_map[i] <= '0;
      end
    end else begin
      if (RBUS_CONF_COUNTERS_Counter_Input_Load) begin
        for (int i = 0; i < BUS_LANES; i++) begin
          lane_map[i][ENTRY_W-1] <= 1'b0;
        end
      end
      if (map_write) begin
        lane_map[lane] <= {RBUS_CONF_COUNTERS_Counter_W_Col_En,
                           RBUS_CONF_COUNTERS_Counter_W_Col_En ? src : {COL_W{1'b0}}};
      end
    end
  end

  always_ff @(posedge RBUS_CONF_COUNTERS_Clk or negedge RBUS_CONF_COUNTERS_Reset) begin
    if (!RBUS_CONF_COUNTERS_Reset) begin
      conf_ok <= 1'b0;
    end else if (RBUS_CONF_COUNTERS_Counter_Input_Load) begin
      conf_ok <= 1'b0;
    end else if (RBUS_CONF_COUNTERS_Set_Conf_Already) begin
      conf_ok <= 1'b1;
    end
  end

  assign RBUS_CONF_COUNTERS_Conf_Already_Ok = conf_ok;
  assign RBUS_CONF_COUNTERS_Map_Valid       = conf_ok;

  for (genvar g = 0; g < BUS_LANES; g++) begin : g_map_out
    assign RBUS_CONF_COUNTERS_Lane_Map[g*ENTRY_W +: ENTRY_W] = lane_map[g];
  end

endmodule

// File: tb/tb_rbus_conf_counters.sv
// Directed bench for rbus_conf_counters: configuration runs, column wrap,
// load/commit collision, async reset mid-run and lane advance without writes.
module tb_rbus_conf_counters;

  localparam int BL = 16;
  localparam int WS = 3;
  localparam int CM = 32;
  localparam int CW = 5;
  localparam int EW = CW + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic w_size_en, w_size_clr, w_col_en, w_col_load, w_col_clr;
  logic input_clr, input_load, bus_en, bus_clr, conf_rutine, set_conf;
  logic [CW-1:0] start_col, input_base;
  logic w_size_flag, bus_flag, conf_ok, map_valid;
  logic [BL*EW-1:0] lane_map;

  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] model [BL];
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rbus_conf_counters #(.BUS_LANES(BL), .W_SIZE(WS), .COL_MAX(CM)) dut (
    .RBUS_CONF_COUNTERS_Clk                 (clk),
    .RBUS_CONF_COUNTERS_Reset               (rst_n),
    .RBUS_CONF_COUNTERS_Counter_W_Size_En   (w_size_en),
    .RBUS_CONF_COUNTERS_Counter_W_Size_Clr  (w_size_clr),
    .RBUS_CONF_COUNTERS_Counter_W_Col_En    (w_col_en),
    .RBUS_CONF_COUNTERS_Counter_W_Col_Load  (w_col_load),
    .RBUS_CONF_COUNTERS_Counter_W_Col_Clr   (w_col_clr),
    .RBUS_CONF_COUNTERS_Counter_Input_Clr   (input_clr),
    .RBUS_CONF_COUNTERS_Counter_Input_Load  (input_load),
    .RBUS_CONF_COUNTERS_Counter_Bus_En      (bus_en),
    .RBUS_CONF_COUNTERS_Counter_Bus_Clr     (bus_clr),
    .RBUS_CONF_COUNTERS_Conf_Rutine         (conf_rutine),
    .RBUS_CONF_COUNTERS_Set_Conf_Already    (set_conf),
    .RBUS_CONF_COUNTERS_Start_Col           (start_col),
    .RBUS_CONF_COUNTERS_Input_Base          (input_base),
    .RBUS_CONF_COUNTERS_Counter_W_Size_Flag (w_size_flag),
    .RBUS_CONF_COUNTERS_Counter_Bus_Flag    (bus_flag),
    .RBUS_CONF_COUNTERS_Conf_Already_Ok     (conf_ok),
    .RBUS_CONF_COUNTERS_Lane_Map            (lane_map),
    .RBUS_CONF_COUNTERS_Map_Valid           (map_valid)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    w_size_en = 1'b0; w_size_clr = 1'b1; w_col_en = 1'b0; w_col_load = 1'b0;
    w_col_clr = 1'b1; input_clr = 1'b1; input_load = 1'b0; bus_en = 1'b0;
    bus_clr = 1'b1; conf_rutine = 1'b0; set_conf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_map(input string tag);
    logic [EW-1:0] e;
    for (int i = 0; i < BL; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < BL; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_e%0d", tag, i), 128'(lane_map[i*EW +: EW]), 128'(e));
    end
  endtask

  task automatic load_cycle(input int start, input int base);
    idle();
    input_load = 1'b1; w_col_load = 1'b1; w_size_clr = 1'b0; bus_clr = 1'b0;
    start_col = CW'(start); input_base = CW'(base);
    for (int i = 0; i < BL; i++) model[i][EW-1] = 1'b0;
    tick();
    idle();
  endtask

  // One configuring cycle c (0-based): phase 0 for c < WS, phase 1 after.
  task automatic conf_cycle(input string tag, input int c, input int start, input int base);
    int col;
    conf_rutine = 1'b1; bus_en = 1'b1;
    w_size_en = (c < WS); w_col_en = (c < WS);
    #2;
    check($sformatf("%s_wflag%0d", tag, c), 128'(w_size_flag), 128'(c == WS - 1));
    check($sformatf("%s_bflag%0d", tag, c), 128'(bus_flag), 128'(c == BL - 1));
    col = (start + base + c) % CM;
    model[c] = (c < WS) ? {1'b1, CW'(col)} : '0;
    tick();
  endtask

  task automatic run_config(input string tag, input int start, input int base);
    load_cycle(start, base);
    for (int c = 0; c < BL; c++) conf_cycle(tag, c, start, base);
    idle();
    set_conf = 1'b1;
    #2;
    check({tag, "_ok_before"}, 128'(conf_ok), 128'(0));
    tick();
    idle();
    check({tag, "_ok_after"}, 128'(conf_ok), 128'(1));
    check({tag, "_map_valid"}, 128'(map_valid), 128'(1));
    check_map(tag);
  endtask

  initial begin
    int k;
    idle();
    start_col = '0; input_base = '0;
    rst_n = 1'b0;
    for (int i = 0; i < BL; i++) model[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      check("rst_map", 128'(lane_map), 128'(0));
      check("rst_ok", 128'(conf_ok), 128'(0));
      check("rst_valid", 128'(map_valid), 128'(0));
      check("rst_flags", 128'({w_size_flag, bus_flag}), 128'(0));
      tick();
    end

    run_config("cfg1", 4, 2);
    run_config("wrap", 30, 1);

    idle();
    set_conf = 1'b1; input_load = 1'b1;
    for (int i = 0; i < BL; i++) model[i][EW-1] = 1'b0;
    tick();
    idle();
    check("coll_ok", 128'(conf_ok), 128'(0));
    check("coll_valid", 128'(map_valid), 128'(0));
    check_map("coll");

    load_cycle(4, 2);
    for (int c = 0; c < WS + 4; c++) conf_cycle("pre_rst", c, 4, 2);
    conf_rutine = 1'b1; bus_en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_map", 128'(lane_map), 128'(0));
    check("arst_ok", 128'(conf_ok), 128'(0));
    check("arst_bflag", 128'(bus_flag), 128'(0));
    idle();
    for (int i = 0; i < BL; i++) model[i] = '0;
    tick();
    #4;
    rst_n = 1'b1;
    tick();
    run_config("recfg", 4, 2);

    idle();
    bus_en = 1'b1; w_col_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("noconf_bflag%0d", i), 128'(bus_flag), 128'(0));
      tick();
    end
    check_map("noconf");
    k = 0;
    while (k < 20) begin
      #2;
      if (bus_flag) break;
      tick();
      k++;
    end
    check("noconf_lane_pos", 128'(k), 128'(10));
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rbus_conf_counters.md
Name: rbus_conf_counters

Overview:
- Counter/lane-map datapath for the reconfigurable bus.
- Consumes the enable/clear/load strobes from the reconfigurable-bus control FSM and returns its two terminal flags plus the configuration-done acknowledge.
- During a configuration routine it writes one lane-map entry per cycle: lane index → source column + valid.
- The committed map drives the bus crossbar in the convolution array.

Parameters:
- BUS_LANES, 16, number of bus lanes (lane-map entries), ≥2.
- W_SIZE, 3, kernel width; lanes written valid before the FSM leaves its first configuring phase, 1..BUS_LANES.
- COL_MAX, 32, number of image columns; column arithmetic is modulo COL_MAX.
- (local) LANE_W = clog2(BUS_LANES).
- (local) COL_W = clog2(COL_MAX).

Ports:
- RBUS_CONF_COUNTERS_Clk  in  1  clock
- RBUS_CONF_COUNTERS_Reset  in  1  asynchronous active-low reset
- RBUS_CONF_COUNTERS_Counter_W_Size_En  in  1  increment kernel-width counter
- RBUS_CONF_COUNTERS_Counter_W_Size_Clr  in  1  active-low sync clear, kernel-width counter
- RBUS_CONF_COUNTERS_Counter_W_Col_En  in  1  increment column counter
- RBUS_CONF_COUNTERS_Counter_W_Col_Load  in  1  load column counter from Start_Col
- RBUS_CONF_COUNTERS_Counter_W_Col_Clr  in  1  active-low sync clear, column counter
- RBUS_CONF_COUNTERS_Counter_Input_Clr  in  1  active-low sync clear, input-offset register
- RBUS_CONF_COUNTERS_Counter_Input_Load  in  1  load input offset from Input_Base; also starts a new configuration
- RBUS_CONF_COUNTERS_Counter_Bus_En  in  1  increment lane counter; write lane-map entry
- RBUS_CONF_COUNTERS_Counter_Bus_Clr  in  1  active-low sync clear, lane counter
- RBUS_CONF_COUNTERS_Conf_Rutine  in  1  configuration routine active
- RBUS_CONF_COUNTERS_Set_Conf_Already  in  1  commit request
- RBUS_CONF_COUNTERS_Start_Col  in  COL_W  first kernel column
- RBUS_CONF_COUNTERS_Input_Base  in  COL_W  input column offset
- RBUS_CONF_COUNTERS_Counter_W_Size_Flag  out  1  last kernel column this cycle
- RBUS_CONF_COUNTERS_Counter_Bus_Flag  out  1  last lane this cycle
- RBUS_CONF_COUNTERS_Conf_Already_Ok  out  1  map committed
- RBUS_CONF_COUNTERS_Lane_Map  out  BUS_LANES*(COL_W+1)  entry i = {valid, col} at bits [i*(COL_W+1) +: COL_W+1]
- RBUS_CONF_COUNTERS_Map_Valid  out  1  Lane_Map usable by crossbar

Behaviour:
- Reset (async, Reset=0): all counters 0, all lane-map entries 0, Conf_Already_Ok=0, Map_Valid=0.
- Counter priority, per counter, each clock: Clr=0 → 0; else Load → load value; else En → +1; else hold.
- Kernel-width counter (wsz):
  - wraps W_SIZE-1 → 0.
  - W_Size_Flag = W_Size_En & (wsz == W_SIZE-1), combinational.
- Column counter (wcol): wraps COL_MAX-1 → 0. Load value is Start_Col; if Start_Col ≥ COL_MAX, load Start_Col − COL_MAX.
- Input offset register (inoff): Load/Clr only, no enable.
- Lane counter (lane):
  - wraps BUS_LANES-1 → 0.
  - Bus_Flag = Bus_En & (lane == BUS_LANES-1), combinational, same-cycle.
- Source column: src = (wcol + inoff) mod COL_MAX, computed COL_W+1 bits wide, conditional subtract.
- Lane-map write: when Bus_En & Conf_Rutine, entry[lane] <= {W_Col_En, W_Col_En ? src : 0}.
  - Configuring phase 0: valid entries.
  - Configuring phase 1: invalid entries.
- Bus_En without Conf_Rutine: lane counter advances, no map write.
- Input_Load=1: all valid bits cleared, Conf_Already_Ok <= 0, Map_Valid <= 0.
- Set_Conf_Already=1 (Input_Load=0): Conf_Already_Ok <= 1 the next edge, sticky until Input_Load or reset. Map_Valid = Conf_Already_Ok.
- Conf_Already_Ok latency from Set_Conf_Already: 1 cycle.
- Simultaneous events:
  - Input_Load & Set_Conf_Already: Input_Load wins.
  - W_Size_Flag & Bus_Flag in the same cycle (W_SIZE=BUS_LANES): both asserted.
- Reset mid-configuration: map cleared immediately, outputs to reset values.

Decomposition:
- Shared package rbus_pkg:
  - localparams for LANE_W/COL_W computation.
  - lane-entry width.
  - mod-add function for column arithmetic.
- One natural sub-module: rbus_mod_counter (width, modulus, active-low Clr, Load, En, terminal-count output), instantiated four times. The lane-map array stays in the top module.

Test Plan:
- Reset release, all strobes idle → Lane_Map=0, flags=0, Conf_Already_Ok=0 for 10 cycles.
- Load cycle with Start_Col=4, Input_Base=2, then 3 cycles of phase-0 strobes and 13 cycles of phase-1 strobes, then Set_Conf_Already → W_Size_Flag on cycle 3; Bus_Flag on cycle 16; entries 0..2 = valid cols 6,7,8; entries 3..15 invalid; Conf_Already_Ok=1 one cycle after Set.
- Start_Col=30, Input_Base=1, COL_MAX=32 → entries 0..2 = cols 31,0,1 (wrap).
- Set_Conf_Already and Input_Load asserted in the same cycle → Conf_Already_Ok stays 0; all valid bits cleared.
- Reset asserted asynchronously mid phase 1 (lane=7) → map and counters 0 without a clock edge; after a clean reconfiguration, map identical to the first run.
- Bus_En with Conf_Rutine=0 for 5 cycles → lane counter=5, Lane_Map unchanged.
